rv32i_id_stage: RTL
===================

// Module: rv32i_id_stage
// PURPOSE
//  Instruction-decode pipeline stage: the producer side of the ALU/execute operand interface. Takes fetched
//  instruction words over a valid/ready handshake, decodes RV32I fields, builds the sign-extended immediate, flags
//  illegal encodings, and presents registered opcode/funct3/funct7/imm/register addresses to EX one cycle later.
// PARAMETERS
//  WIDTH  32  data/PC/immediate width (only 32 is supported)
// PORTS
//  i_clk        in   1      clock; all state updates on rising edge
//  i_rst        in   1      reset, synchronous, active-high
//  i_valid      in   1      IF presents i_instr/i_pc
//  o_ready      out  1      stage accepts: !o_valid | i_ready (combinational)
//  i_instr      in   32     instruction word
//  i_pc         in   WIDTH  PC of i_instr
//  i_flush      in   1      kill the held entry and the entry being offered
//  o_valid      out  1      decoded entry valid to EX
//  i_ready      in   1      EX consumes the entry
//  o_opcode     out  7      instr[6:0]
//  o_funct3     out  3      instr[14:12]
//  o_funct7     out  7      instr[31:25]
//  o_rs1_addr   out  5      instr[19:15]
//  o_rs2_addr   out  5      instr[24:20]
//  o_rd_addr    out  5      instr[11:7]
//  o_imm        out  WIDTH  sign-extended immediate per format
//  o_pc         out  WIDTH  registered i_pc
//  o_rd_we      out  1      register write enable
//  o_illegal    out  1      illegal-instruction flag
//  o_is_muldiv  out  1      RV32M op (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: o_valid=0; all other outputs 0. Reset during a held/stalled entry discards it.
//  - Capture when i_valid & o_ready & !i_flush: all outputs loaded next edge, o_valid=1. Latency 1 cycle.
//  - Hold: o_valid & !i_ready -> every output stable, no capture; o_ready=0.
//  - Drain: o_valid & i_ready & !i_valid -> o_valid=0 next edge; data outputs hold last value.
//  - Back-to-back: o_valid & i_ready & i_valid -> new entry replaces old; full throughput, 1 instr/cycle.
//  - i_flush: highest priority below reset; o_valid=0 next edge regardless of i_valid/i_ready.
//  - Immediate: I (LOAD, OP-IMM, JALR) {20{i[31]},i[31:20]}; S {i[31:25],i[11:7]} sext;
//    B {i[31],i[7],i[30:25],i[11:8],0} sext; U {i[31:12],12'b0}; J {i[31],i[19:12],i[20],i[30:21],0} sext;
//    OP/FENCE/SYSTEM -> 0. Shift-immediates pass I-format raw (shamt in imm[4:0]).
//  - o_rd_we=1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP when rd!=0 and !illegal; else 0.
//  - o_illegal=1 if: instr[1:0]!=2'b11; opcode not in {0110111,0010111,1101111,1100111,1100011,0000011,
//    0100011,0010011,0110011,0001111,1110011}; JALR funct3!=0; BRANCH funct3 in {010,011};
//    LOAD funct3 in {011,110,111}; STORE funct3>010; OP-IMM funct3=001 with funct7!=0;
//    OP-IMM funct3=101 with funct7 not in {0000000,0100000}; OP funct7=0100000 with funct3 not in {000,101};
//    OP funct7 any other value except 0000000 (and 0000001 when RV32M_EN). Illegal entries still go valid to EX.
// CONFIGURATION
//  RV32I_ID_RV32M_EN defined: OP with funct7=0000001 (any funct3) legal, o_is_muldiv=1, o_rd_we per rd rule.
//  Not defined: such encodings o_illegal=1, o_rd_we=0; o_is_muldiv tied 0.
// TESTING
//  - 0x00500093 (addi x1,x0,5), i_ready=1 -> next cycle o_valid=1, opcode 0x13, rd=1, imm=5, rd_we=1, illegal=0.
//  - 0x402081B3 (sub x3,x1,x2) -> funct7=0x20, rs1=1, rs2=2, rd=3, imm=0; 0x0000_0000 -> illegal=1, rd_we=0.
//  - 0xFE000EE3 (beq x0,x0,-4) -> imm=0xFFFFFFFC, rd_we=0, illegal=0.
//  - 0x027302B3 (mul x5,x6,x7) -> with macro: is_muldiv=1, illegal=0, rd_we=1; without: illegal=1, rd_we=0.
//  - i_ready=0 for 3 cycles with entry held and i_valid=1 -> o_ready=0, outputs stable; i_ready=1 -> next entry appears.
//  - i_flush with i_valid=1 -> o_valid=0 next cycle; i_rst during stall -> o_valid=0, outputs 0 next cycle.

Source files
------------

// File: rtl/rv32i_id_stage_if.sv
// IF->ID->EX handshake bundle for the RV32I decode stage.
// master is the decode stage itself; slave is the surrounding IF/EX environment.
interface rv32i_id_stage_if #(
    parameter int WIDTH = 32
);
    logic             i_valid;
    logic             o_ready;
    logic [31:0]      i_instr;
    logic [WIDTH-1:0] i_pc;
    logic             i_flush;
    logic             o_valid;
    logic             i_ready;
    logic [6:0]       o_opcode;
    logic [2:0]       o_funct3;
    logic [6:0]       o_funct7;
    logic [4:0]       o_rs1_addr;
    logic [4:0]       o_rs2_addr;
    logic [4:0]       o_rd_addr;
    logic [WIDTH-1:0] o_imm;
    logic [WIDTH-1:0] o_pc;
    logic             o_rd_we;
    logic             o_illegal;
    logic             o_is_muldiv;

    modport master (
        input  i_valid, i_instr, i_pc, i_flush, i_ready,
        output o_ready, o_valid, o_opcode, o_funct3, o_funct7, o_rs1_addr,
               o_rs2_addr, o_rd_addr, o_imm, o_pc, o_rd_we, o_illegal, o_is_muldiv
    );

    modport slave (
        output i_valid, i_instr, i_pc, i_flush, i_ready,
        input  o_ready, o_valid, o_opcode, o_funct3, o_funct7, o_rs1_addr,
               o_rs2_addr, o_rd_addr, o_imm, o_pc, o_rd_we, o_illegal, o_is_muldiv
    );
endinterface

// File: rtl/rv32i_id_stage.sv
// RV32I instruction-decode stage: one-entry registered skid toward EX with immediate build and illegal detection.
// Optional RV32M acceptance is enabled by defining RV32I_ID_RV32M_EN.
module rv32i_id_stage #(
    parameter int WIDTH = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    rv32i_id_stage_if.master     bus
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MULD = 7'b0000001;

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;

    logic [WIDTH-1:0] imm_next;
    logic             illegal_next;
    logic             writes_rd;
    logic             rd_we_next;
    logic             muldiv_next;

    logic             valid_reg;
    logic [6:0]       opcode_reg;
    logic [2:0]       funct3_reg;
    logic [6:0]       funct7_reg;
    logic [4:0]       rs1_reg;
    logic [4:0]       rs2_reg;
    logic [4:0]       rd_reg;
    logic [WIDTH-1:0] imm_reg;
    logic [WIDTH-1:0] pc_reg;
    logic             rd_we_reg;
    logic             illegal_reg;
    logic             muldiv_reg;

    logic ready;
    logic capture;

    assign instr   = bus.i_instr;
    assign opcode  = instr[6:0];
    assign funct3  = instr[14:12];
    assign funct7  = instr[31:25];
    assign rd      = instr[11:7];

    assign ready   = !valid_reg || bus.i_ready;
    assign capture = bus.i_valid && ready && !bus.i_flush;

    always_comb begin
        imm_next     = '0;
        illegal_next = 1'b0;
        writes_rd    = 1'b0;
        muldiv_next  = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                imm_next  = {instr[31:12], 12'b0};
                writes_rd = 1'b1;
            end
            OPC_JAL: begin
                imm_next  = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
                writes_rd = 1'b1;
            end
            OPC_JALR: begin
                imm_next     = {{20{instr[31]}}, instr[31:20]};
                writes_rd    = 1'b1;
                illegal_next = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                imm_next     = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
                illegal_next = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OPC_LOAD: begin
                imm_next     = {{20{instr[31]}}, instr[31:20]};
                writes_rd    = 1'b1;
                illegal_next = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OPC_STORE: begin
                imm_next     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                illegal_next = (funct3 > 3'b010);
            end
            OPC_OPIMM: begin
                // Shift amounts stay in imm[4:0]; funct7 bits only qualify legality
                imm_next  = {{20{instr[31]}}, instr[31:20]};
                writes_rd = 1'b1;
                if (funct3 == 3'b001)
                    illegal_next = (funct7 != F7_ZERO);
                else if (funct3 == 3'b101)
                    illegal_next = (funct7 != F7_ZERO) && (funct7 != F7_ALT);
            end
            OPC_OP: begin
                writes_rd = 1'b1;
                if (funct7 == F7_ALT)
                    illegal_next = (funct3 != 3'b000) && (funct3 != 3'b101);
`ifdef RV32I_ID_RV32M_EN
                else if (funct7 == F7_MULD)
                    muldiv_next = 1'b1;
`endif
                else if (funct7 != F7_ZERO)
                    illegal_next = 1'b1;
            end
            OPC_FENCE, OPC_SYSTEM: begin
                imm_next = '0;
            end
            default: illegal_next = 1'b1;
        endcase
        // Compressed/reserved low bits are never legal, whatever the opcode decode said
        if (instr[1:0] != 2'b11)
            illegal_next = 1'b1;
        rd_we_next = writes_rd && (rd != 5'd0) && !illegal_next;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_reg   <= 1'b0;
            opcode_reg  <= '0;
            funct3_reg  <= '0;
            funct7_reg  <= '0;
            rs1_reg     <= '0;
            rs2_reg     <= '0;
            rd_reg      <= '0;
            imm_reg     <= '0;
            pc_reg      <= '0;
            rd_we_reg   <= 1'b0;
            illegal_reg <= 1'b0;
            muldiv_reg  <= 1'b0;
        end else if (bus.i_flush) begin
            valid_reg <= 1'b0;
        end else if (capture) begin
            valid_reg   <= 1'b1;
            opcode_reg  <= opcode;
            funct3_reg  <= funct3;
            funct7_reg  <= funct7;
            rs1_reg     <= instr[19:15];
            rs2_reg     <= instr[24:20];
            rd_reg      <= rd;
            imm_reg     <= imm_next;
            pc_reg      <= bus.i_pc;
            rd_we_reg   <= rd_we_next;
            illegal_reg <= illegal_next;
            muldiv_reg  <= muldiv_next;
        end else if (bus.i_ready) begin
            // Drain: data fields keep the last entry
            valid_reg <= 1'b0;
        end
    end

    assign bus.o_ready     = ready;
    assign bus.o_valid     = valid_reg;
    assign bus.o_opcode    = opcode_reg;
    assign bus.o_funct3    = funct3_reg;
    assign bus.o_funct7    = funct7_reg;
    assign bus.o_rs1_addr  = rs1_reg;
    assign bus.o_rs2_addr  = rs2_reg;
    assign bus.o_rd_addr   = rd_reg;
    assign bus.o_imm       = imm_reg;
    assign bus.o_pc        = pc_reg;
    assign bus.o_rd_we     = rd_we_reg;
    assign bus.o_illegal   = illegal_reg;
`ifdef RV32I_ID_RV32M_EN
    assign bus.o_is_muldiv = muldiv_reg;
`else
    assign bus.o_is_muldiv = 1'b0;
`endif
endmodule
